// File: rtl/seg7_rx_decoder.sv
// rtl/seg7_rx_decoder.sv - active-low 7-segment stream decoder packing NDIGITS hex nibbles per word
// Optional build macro SEG7RX_BLANK_EN: accept 0x7F (all segments off) as a legal blank digit.
module seg7_rx_decoder #(
    parameter int NDIGITS = 6
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [6:0]             seg_in,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    output logic [4*NDIGITS-1:0]   word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [NDIGITS-1:0]     digit_err_mask,
    output logic                   err
);

    localparam int CW = $clog2(NDIGITS + 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt;
    logic [4*NDIGITS-1:0]   acc, acc_next;
    logic [4*NDIGITS+3:0]   acc_shift;
    logic [NDIGITS-1:0]     mask_acc, mask_next;
    logic [NDIGITS:0]       mask_shift;
    logic [3:0]             nibble;
    logic                   bad;
    logic                   accept, word_done, word_take, seg_ready_next;

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (seg_in)
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h18: nibble = 4'h9;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
`ifdef SEG7RX_BLANK_EN
            7'h7F: nibble = 4'h0;
`endif
            default: bad = 1'b1;
        endcase
    end

    // Shift through a wider vector so NDIGITS = 1 needs no special-cased slice.
    always_comb begin
        acc_shift  = {acc, nibble};
        mask_shift = {mask_acc, bad};
        acc_next   = acc_shift[4*NDIGITS-1:0];
        mask_next  = mask_shift[NDIGITS-1:0];
    end

    assign accept    = seg_valid && seg_ready;
    assign word_done = accept && (cnt == CW'(NDIGITS - 1));
    assign word_take = (state == HOLD) && word_valid && word_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (word_done) state_next = HOLD;
            HOLD:    if (word_take) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        seg_ready_next = (state_next == COLLECT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            seg_ready      <= 1'b0;
            word_out       <= '0;
            digit_err_mask <= '0;
            err            <= 1'b0;
            word_valid     <= 1'b0;
            acc            <= '0;
            mask_acc       <= '0;
            cnt            <= '0;
        end else begin
            seg_ready <= seg_ready_next;
            if (word_done) begin
                word_out       <= acc_next;
                digit_err_mask <= mask_next;
                err            <= |mask_next;
                word_valid     <= 1'b1;
                acc            <= '0;
                mask_acc       <= '0;
                cnt            <= '0;
            end else if (accept) begin
                acc      <= acc_next;
                mask_acc <= mask_next;
                cnt      <= cnt + CW'(1);
            end
            if (word_take) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// tb/tb_seg7_rx_decoder.sv - randomized self-checking bench for seg7_rx_decoder against a queue-based model
module tb_seg7_rx_decoder;

    localparam int N = 6;

    logic             CLOCK_50 = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       seg_in = 7'h00;
    logic             seg_valid = 1'b0;
    logic             seg_ready;
    logic [4*N-1:0]   word_out;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic [N-1:0]     digit_err_mask;
    logic             err;

    seg7_rx_decoder #(.NDIGITS(N)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .seg_in         (seg_in),
        .seg_valid      (seg_valid),
        .seg_ready      (seg_ready),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .digit_err_mask (digit_err_mask),
        .err            (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [6:0] legal [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         legal_nib [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 10, 11, 12, 13, 14, 15};

    int          dq[$];
    bit          bq[$];
    logic [31:0] exp_word[$];
    logic [31:0] exp_mask[$];
    int          words_pushed = 0;
    int          words_seen = 0;

    function automatic void decode_ref(input logic [6:0] p, output int nib, output bit bad);
        nib = 0;
        bad = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (legal[k] == p) begin
                nib = legal_nib[k];
                bad = 1'b0;
            end
        end
`ifdef SEG7RX_BLANK_EN
        if (p == 7'h7F) bad = 1'b0;
`endif
    endfunction

    task automatic model_accept(input logic [6:0] p);
        int nib;
        bit bad;
        logic [31:0] w, m;
        decode_ref(p, nib, bad);
        dq.push_back(nib);
        bq.push_back(bad);
        if (dq.size() == N) begin
            w = 0;
            m = 0;
            for (int j = 0; j < N; j++) begin
                w = w * 16 + 32'(dq[j]);
                m = (m << 1) | 32'(bq[j]);
            end
            exp_word.push_back(w);
            exp_mask.push_back(m);
            words_pushed++;
            dq.delete();
            bq.delete();
        end
    endtask

    logic [31:0] mon_w, mon_m;
    always @(negedge CLOCK_50) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_word.size() == 0) begin
                check("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
            end else begin
                mon_w = exp_word.pop_front();
                mon_m = exp_mask.pop_front();
                check("word", 32'(word_out), mon_w);
                check("mask", 32'(digit_err_mask), mon_m);
                check("err", 32'(err), 32'(|mon_m));
            end
            words_seen++;
        end
    end

    task automatic send(input logic [6:0] p);
        int t = 0;
        seg_in = p;
        seg_valid = 1'b1;
        while (!seg_ready && t < 50) begin
            @(posedge CLOCK_50);
            #1;
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'(t), 32'(0));
        @(posedge CLOCK_50);
        model_accept(p);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        word_ready = 1'b1;
        while (word_valid && t < 50) begin
            @(posedge CLOCK_50);
            #1;
            t++;
        end
        if (t >= 50) check("drain_timeout", 32'(t), 32'(0));
    endtask

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(0, 4) == 0) return 7'($urandom);
        return legal[$urandom_range(0, 16)];
    endfunction

    logic [6:0]  grp [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h18, 7'h10, 7'h08,
                              7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40};
    logic [31:0] grp_word [3] = '{32'h012345, 32'h67899A, 32'hBCDEF0};
    logic [6:0]  bad_pats [6] = '{7'h00, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h00};
    logic [31:0] cap;

    initial begin
        // Reset held three cycles with seg_valid asserted
        reset = 1'b1;
        seg_valid = 1'b1;
        seg_in = 7'h40;
        word_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("rst_seg_ready", 32'(seg_ready), 32'(0));
            check("rst_word_valid", 32'(word_valid), 32'(0));
            check("rst_word_out", 32'(word_out), 32'(0));
            check("rst_mask", 32'(digit_err_mask), 32'(0));
            check("rst_err", 32'(err), 32'(0));
        end
        reset = 1'b0;
        seg_valid = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("post_rst_seg_ready", 32'(seg_ready), 32'(1));

        // Full decode table, back-to-back
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 6; i++) send(grp[g*6+i]);
            check("tbl_valid", 32'(word_valid), 32'(1));
            check("tbl_word", 32'(word_out), grp_word[g]);
            check("tbl_err", 32'(err), 32'(0));
        end
        drain();

        // Backpressure while HOLD
        word_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(legal[$urandom_range(0, 16)]);
        cap = 32'(word_out);
        check("bp_valid", 32'(word_valid), 32'(1));
        seg_valid = 1'b1;
        seg_in = 7'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("bp_seg_ready", 32'(seg_ready), 32'(0));
            check("bp_hold_valid", 32'(word_valid), 32'(1));
            check("bp_stable", 32'(word_out), cap);
        end
        seg_valid = 1'b0;
        word_ready = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("bp_ready_back", 32'(seg_ready), 32'(1));
        check("bp_valid_clr", 32'(word_valid), 32'(0));
        for (int i = 0; i < 6; i++) send(legal[$urandom_range(0, 16)]);
        drain();

        // Unrecognised third digit
        for (int i = 0; i < 6; i++) send(bad_pats[i]);
        check("bad_word", 32'(word_out), 32'h880888);
`ifdef SEG7RX_BLANK_EN
        check("bad_mask", 32'(digit_err_mask), 32'h00);
        check("bad_err", 32'(err), 32'(0));
`else
        check("bad_mask", 32'(digit_err_mask), 32'h08);
        check("bad_err", 32'(err), 32'(1));
`endif
        drain();

        // Alternating valid gaps with garbage on seg_in
        for (int i = 0; i < 6; i++) begin
            send(legal[$urandom_range(0, 16)]);
            seg_in = 7'($urandom);
            @(posedge CLOCK_50);
            #1;
        end
        drain();

        // Reset mid-word
        for (int i = 0; i < 4; i++) send(rand_pat());
        reset = 1'b1;
        dq.delete();
        bq.delete();
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        check("midrst_valid", 32'(word_valid), 32'(0));
        for (int i = 0; i < 6; i++) send(rand_pat());
        drain();

        // Randomized words with random gaps
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < N; i++) begin
                send(rand_pat());
                if ($urandom_range(0, 1) == 1) begin
                    seg_in = 7'($urandom);
                    @(posedge CLOCK_50);
                    #1;
                end
            end
        end
        drain();
        repeat (3) @(posedge CLOCK_50);
        #1;

        check("pending_words", 32'(exp_word.size()), 32'(0));
        check("words_seen", 32'(words_seen), 32'(words_pushed));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
